// File: rtl/sig_delay_pkg.sv
// sig_delay_pkg: shared constants and helpers for the sig_delay_line slice.
//   SIG_DELAY_DEF_BUS_BITS : default bus width of the delay line
//   SIG_DELAY_DEF_DELAY    : default latency in clk cycles
//   sig_delay_def_bus_t    : bus vector at the default width
//   sig_delay_taps()       : number of chain taps (input tap plus one per stage)
package sig_delay_pkg;

  localparam int unsigned SIG_DELAY_DEF_BUS_BITS = 1;
  localparam int unsigned SIG_DELAY_DEF_DELAY    = 1;

  typedef logic [SIG_DELAY_DEF_BUS_BITS-1:0] sig_delay_def_bus_t;

  // Tap 0 is the raw input and tap k is the output of stage k-1, so a chain
  // of 'delay' stages has delay+1 taps (one tap when delay is zero).
  function automatic int unsigned sig_delay_taps(input int unsigned delay);
    return delay + 1;
  endfunction

endpackage

// File: rtl/sig_delay_stage.sv
// sig_delay_stage: one BUS_BITS-wide register of the delay chain.
//   clk  in  1         rising-edge clock
//   rst  in  1         asynchronous active-high clear
//   ce   in  1         stage enable (only when SIG_DELAY_CE_EN is defined)
//   i_d  in  BUS_BITS  value captured on the clock edge
//   o_q  out BUS_BITS  registered value
// Optional feature macro: SIG_DELAY_CE_EN.
module sig_delay_stage
  import sig_delay_pkg::*;
#(
  parameter int unsigned BUS_BITS = SIG_DELAY_DEF_BUS_BITS
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SIG_DELAY_CE_EN
  input  logic                ce,
`endif
  input  logic [BUS_BITS-1:0] i_d,
  output logic [BUS_BITS-1:0] o_q
);

  logic [BUS_BITS-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
`ifdef SIG_DELAY_CE_EN
    end else if (ce) begin
`else
    end else begin
`endif
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sig_delay_line.sv
// sig_delay_line: fixed-latency register delay for a bus of sideband signals.
//   clk    in  1         rising-edge clock
//   rst    in  1         asynchronous active-high reset, clears all stages
//   ce     in  1         chain enable (only when SIG_DELAY_CE_EN is defined)
//   i_bus  in  BUS_BITS  bus to delay
//   o_bus  out BUS_BITS  i_bus delayed by DELAY enabled clock cycles
// Parameters: BUS_BITS >= 1, DELAY >= 0 (DELAY=0 is a plain wire).
// Optional feature macro: SIG_DELAY_CE_EN.
module sig_delay_line
  import sig_delay_pkg::*;
#(
  parameter int unsigned BUS_BITS = SIG_DELAY_DEF_BUS_BITS,
  parameter int unsigned DELAY    = SIG_DELAY_DEF_DELAY
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SIG_DELAY_CE_EN
  input  logic                ce,
`endif
  input  logic [BUS_BITS-1:0] i_bus,
  output logic [BUS_BITS-1:0] o_bus
);

  localparam int unsigned TAPS = sig_delay_taps(DELAY);

  logic [BUS_BITS-1:0] w_tap [TAPS];

  assign w_tap[0] = i_bus;
  assign o_bus    = w_tap[DELAY];

  if (DELAY == 0) begin : g_wire
    // No registers exist, so clock, reset and enable are deliberately sunk.
    logic w_unused;
`ifdef SIG_DELAY_CE_EN
    assign w_unused = &{1'b0, clk, rst, ce};
`else
    assign w_unused = &{1'b0, clk, rst};
`endif
  end else begin : g_chain
    for (genvar g = 0; g < DELAY; g++) begin : g_stage
      sig_delay_stage #(
        .BUS_BITS (BUS_BITS)
      ) u_stage (
        .clk (clk),
        .rst (rst),
`ifdef SIG_DELAY_CE_EN
        .ce  (ce),
`endif
        .i_d (w_tap[g]),
        .o_q (w_tap[g+1])
      );
    end
  end

endmodule

// File: tb/tb_sig_delay_line.sv
// tb_sig_delay_line: directed bench for sig_delay_line.
// Covers DELAY=5 (2-bit and 8-bit), DELAY=3 async reset mid-stream,
// DELAY=0 pass-through, and, when SIG_DELAY_CE_EN is defined, DELAY=4 with a
// clock-enable stall.
module tb_sig_delay_line;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // DUT A: BUS_BITS=2, DELAY=5
  logic       rst_a = 1'b1;
  logic [1:0] i_a   = '0;
  logic [1:0] o_a;
  // DUT B: BUS_BITS=8, DELAY=5
  logic       rst_b = 1'b1;
  logic [7:0] i_b   = '0;
  logic [7:0] o_b;
  // DUT C: BUS_BITS=8, DELAY=3
  logic       rst_c = 1'b1;
  logic [7:0] i_c   = '0;
  logic [7:0] o_c;
  // DUT D: BUS_BITS=8, DELAY=0
  logic       rst_d = 1'b1;
  logic [7:0] i_d   = '0;
  logic [7:0] o_d;

  sig_delay_line #(.BUS_BITS(2), .DELAY(5)) dut_a (
    .clk(clk), .rst(rst_a),
`ifdef SIG_DELAY_CE_EN
    .ce(1'b1),
`endif
    .i_bus(i_a), .o_bus(o_a));

  sig_delay_line #(.BUS_BITS(8), .DELAY(5)) dut_b (
    .clk(clk), .rst(rst_b),
`ifdef SIG_DELAY_CE_EN
    .ce(1'b1),
`endif
    .i_bus(i_b), .o_bus(o_b));

  sig_delay_line #(.BUS_BITS(8), .DELAY(3)) dut_c (
    .clk(clk), .rst(rst_c),
`ifdef SIG_DELAY_CE_EN
    .ce(1'b1),
`endif
    .i_bus(i_c), .o_bus(o_c));

  sig_delay_line #(.BUS_BITS(8), .DELAY(0)) dut_d (
    .clk(clk), .rst(rst_d),
`ifdef SIG_DELAY_CE_EN
    .ce(1'b0),
`endif
    .i_bus(i_d), .o_bus(o_d));

`ifdef SIG_DELAY_CE_EN
  // DUT E: BUS_BITS=8, DELAY=4, with clock enable
  logic       rst_e = 1'b1;
  logic       ce_e  = 1'b1;
  logic [7:0] i_e   = '0;
  logic [7:0] o_e;

  sig_delay_line #(.BUS_BITS(8), .DELAY(4)) dut_e (
    .clk(clk), .rst(rst_e), .ce(ce_e), .i_bus(i_e), .o_bus(o_e));
`endif

  initial begin
    logic [1:0] stim_a [10];
    logic [1:0] exp_a  [10];
    logic [7:0] hist_b [$];
    logic [7:0] stim_c [5];
    logic [7:0] exp_c  [5];
    logic [7:0] vec_d  [6];

    stim_a = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_a  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    stim_c = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_c  = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    vec_d  = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80};

    // Reset state: held in reset with a nonzero input, delayed outputs read 0.
    i_b = 8'hFF;
    i_c = 8'hFF;
    repeat (3) @(negedge clk);
    check_eq("rst_a", {6'b0, o_a}, 8'h00);
    check_eq("rst_b", o_b, 8'h00);
    check_eq("rst_c", o_c, 8'h00);
    i_b = '0;
    i_c = '0;

    // Test 1: 2-bit, DELAY=5 sequence from release.
    rst_a = 1'b0;
    i_a   = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("t1_seq%0d", k), {6'b0, o_a}, {6'b0, exp_a[k]});
      i_a = stim_a[k];
    end

    // Test 2: random 8-bit stream, DELAY=5.
    rst_b = 1'b0;
    i_b   = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k >= 5) check_eq("t2_stream", o_b, hist_b[k-5]);
      else        check_eq("t2_zero", o_b, 8'h00);
      i_b = 8'($urandom);
      hist_b.push_back(i_b);
    end

    // Test 3: DELAY=3, asynchronous reset with values in flight.
    rst_c = 1'b0;
    i_c   = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_c = 8'(8'h11 * (k + 1));
    end
    @(negedge clk);
    check_eq("t3_inflight", o_c, 8'h33);
    rst_c = 1'b1;
    i_c   = '0;
    #1;
    check_eq("t3_async_clr", o_c, 8'h00);
    repeat (2) begin
      @(negedge clk);
      check_eq("t3_held", o_c, 8'h00);
    end
    rst_c = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("t3_post%0d", k), o_c, exp_c[k]);
      i_c = stim_c[k];
    end

    // Test 4: DELAY=0 pass-through, reset toggled with no effect.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rst_d = k[0];
      i_d   = vec_d[k];
      #1;
      check_eq("t4_comb", o_d, vec_d[k]);
      @(posedge clk);
      #1;
      check_eq("t4_edge", o_d, vec_d[k]);
    end

`ifdef SIG_DELAY_CE_EN
    // Test 5: DELAY=4 with a 3-cycle ce stall mid-stream.
    begin
      logic [7:0] acc [$];
      logic [7:0] exp_e;
      rst_e = 1'b0;
      i_e   = '0;
      ce_e  = 1'b1;
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        exp_e = (acc.size() >= 4) ? acc[acc.size()-4] : 8'h00;
        check_eq($sformatf("t5_ce%0d", k), o_e, exp_e);
        i_e  = (k < 16) ? 8'(k + 1) : 8'h00;
        ce_e = !(k >= 6 && k <= 8);
        if (ce_e) acc.push_back(i_e);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
